// File: rtl/multi_queue_fifo.sv
// Several independent queues threaded through one shared data RAM by a link array.
// The link array holds a free list plus one list per queue. After reset, an init sweep builds the free list.
module multi_queue_fifo #(
   parameter int WIDTH              = 8,
   parameter int DEPTH              = 32,
   parameter int FIFOS              = 8,
   parameter int LOG2_DEPTH         = $clog2(DEPTH),
   parameter int LOG2_FIFOS         = $clog2(FIFOS),
   parameter int ALMOST_FULL_THRESH = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic [LOG2_FIFOS-1:0]             push_fifo,
   input  logic [WIDTH-1:0]                  d,
   input  logic                              pop,
   input  logic [LOG2_FIFOS-1:0]             pop_fifo,
   output logic [WIDTH-1:0]                  q,
   output logic                              q_valid,
   output logic [LOG2_FIFOS-1:0]             q_fifo,
   output logic                              ready,
   output logic [FIFOS-1:0]                  empty,
   output logic [FIFOS*(LOG2_DEPTH+1)-1:0]   count,
   output logic [LOG2_DEPTH:0]               free_count,
   output logic                              full,
   output logic                              almost_full,
   output logic                              overflow,
   output logic                              underflow
);

   localparam int CW = LOG2_DEPTH + 1;

   typedef enum logic {INIT, RUN} state_t;
   state_t state, state_next;

   logic [LOG2_DEPTH-1:0] sweep;
   logic [WIDTH-1:0]      data_ram [DEPTH];
   logic [LOG2_DEPTH-1:0] link     [DEPTH];
   logic [LOG2_DEPTH-1:0] head     [FIFOS];
   logic [LOG2_DEPTH-1:0] tail     [FIFOS];
   logic [CW-1:0]         cnt      [FIFOS];
   logic [LOG2_DEPTH-1:0] free_head;
   logic [CW-1:0]         free_cnt;

   logic                  push_ok, pop_ok, same_q, refill_head;
   logic [LOG2_DEPTH-1:0] h, e;
   logic                  link_we;
   logic [LOG2_DEPTH-1:0] link_addr, link_wdata;

   always_comb begin
      state_next = state;
      if (state == INIT && sweep == LOG2_DEPTH'(DEPTH - 1))
         state_next = RUN;
   end

   assign ready = (state == RUN);

   // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
   always_comb begin
      push_ok     = ready && push && (free_cnt != '0);
      pop_ok      = ready && pop && (cnt[pop_fifo] != '0);
      same_q      = (push_fifo == pop_fifo);
      h           = head[pop_fifo];
      // A node freed by a pop is handed straight to a same-cycle push, so only one link write is needed.
      e           = pop_ok ? h : free_head;
      refill_head = (cnt[push_fifo] == '0) || (pop_ok && same_q && cnt[pop_fifo] == CW'(1));
      link_we     = 1'b0;
      link_addr   = '0;
      link_wdata  = '0;
      if (!ready) begin
         link_we    = 1'b1;
         link_addr  = sweep;
         link_wdata = LOG2_DEPTH'(sweep + 1'b1);
      end else if (push_ok && cnt[push_fifo] != '0) begin
         link_we    = 1'b1;
         link_addr  = tail[push_fifo];
         link_wdata = e;
      end else if (pop_ok && !push_ok) begin
         link_we    = 1'b1;
         link_addr  = h;
         link_wdata = free_head;
      end
   end

   // NOTE: the RAMs carry no reset; the init sweep rebuilds the link array, and data is only read after it is written.
   always_ff @(posedge clk) begin
      if (push_ok)
         data_ram[e] <= d;
      if (link_we)
         link[link_addr] <= link_wdata;
   end

   // NOTE: all state registers use non-blocking assignments so every read sees the pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         sweep     <= '0;
         free_head <= '0;
         free_cnt  <= CW'(DEPTH);
         q         <= '0;
         q_valid   <= 1'b0;
         q_fifo    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < FIFOS; i++) begin
            head[i] <= '0;
            tail[i] <= '0;
            cnt[i]  <= '0;
         end
      end else begin
         state     <= state_next;
         if (!ready)
            sweep <= sweep + 1'b1;
         overflow  <= ready && push && !push_ok;
         underflow <= ready && pop && !pop_ok;
         q_valid   <= pop_ok;
         if (pop_ok) begin
            q                <= data_ram[h];
            q_fifo           <= pop_fifo;
            head[pop_fifo]   <= link[h];
         end
         if (push_ok) begin
            tail[push_fifo] <= e;
            if (refill_head)
               head[push_fifo] <= e;
         end
         if (push_ok && !pop_ok) begin
            free_head <= link[free_head];
            free_cnt  <= free_cnt - 1'b1;
         end else if (pop_ok && !push_ok) begin
            free_head <= h;
            free_cnt  <= free_cnt + 1'b1;
         end
         for (int i = 0; i < FIFOS; i++) begin
            if (push_ok && push_fifo == LOG2_FIFOS'(i) && !(pop_ok && pop_fifo == LOG2_FIFOS'(i)))
               cnt[i] <= cnt[i] + 1'b1;
            else if (pop_ok && pop_fifo == LOG2_FIFOS'(i) && !(push_ok && push_fifo == LOG2_FIFOS'(i)))
               cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   always_comb begin
      count = '0;
      empty = '0;
      for (int i = 0; i < FIFOS; i++) begin
         count[i*CW +: CW] = cnt[i];
         empty[i]          = (cnt[i] == '0);
      end
   end

   assign free_count  = free_cnt;
   assign full        = (free_cnt == '0);
   assign almost_full = (free_cnt < CW'(ALMOST_FULL_THRESH));

endmodule

// File: tb/tb_multi_queue_fifo.sv
// Directed bench for multi_queue_fifo at the default sizes (DEPTH 32, 8 queues).
// Each scenario task compares outputs against hand-computed values.
module tb_multi_queue_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0, pop = 1'b0;
   logic [2:0] push_fifo = '0, pop_fifo = '0;
   logic [7:0] d = '0;
   logic [7:0] q;
   logic       q_valid, ready, full, almost_full, overflow, underflow;
   logic [2:0] q_fifo;
   logic [7:0] empty;
   logic [47:0] count;
   logic [5:0] free_count;

   int passed = 0;
   int total  = 0;

   multi_queue_fifo dut (
      .clk(clk), .rst(rst), .push(push), .push_fifo(push_fifo), .d(d),
      .pop(pop), .pop_fifo(pop_fifo), .q(q), .q_valid(q_valid), .q_fifo(q_fifo),
      .ready(ready), .empty(empty), .count(count), .free_count(free_count),
      .full(full), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] cnt_of(input int i);
      return count[i*6 +: 6];
   endfunction

   // Drive one cycle of stimulus at negedge; return 1 ns after the capturing edge.
   task automatic cyc(input logic pu, input logic [2:0] pf, input logic [7:0] dd,
                      input logic po, input logic [2:0] pof);
      @(negedge clk);
      push = pu; push_fifo = pf; d = dd; pop = po; pop_fifo = pof;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (ready !== 1'b1) $display("FAIL wait_ready: ready=%0b after %0d cycles, required 1", ready, n);
      else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      total++;
      if ({q, q_valid, q_fifo, ready} !== 13'h0)
         $display("FAIL reset_q: q=%0h q_valid=%0b q_fifo=%0d ready=%0b, required all 0", q, q_valid, q_fifo, ready);
      else passed++;
      total++;
      if (empty !== 8'hFF || count !== 48'h0 || free_count !== 6'd32 || full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL reset_status: empty=%0h count=%0h free=%0d full=%0b af=%0b ovf=%0b unf=%0b, required ff/0/32/0/0/0/0",
                  empty, count, free_count, full, almost_full, overflow, underflow);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      repeat (31) @(posedge clk);
      #1;
      total++;
      if (ready !== 1'b0) $display("FAIL init_ready_early: ready=%0b after 31 edges, required 0", ready);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (ready !== 1'b1 || free_count !== 6'd32 || empty !== 8'hFF)
         $display("FAIL init_done: ready=%0b free=%0d empty=%0h, required 1/32/ff", ready, free_count, empty);
      else passed++;
   endtask

   task automatic test_fill();
      int bad = 0;
      for (int i = 0; i < 32; i++) cyc(1'b1, 3'd3, 8'(i), 1'b0, 3'd0);
      total++;
      if (full !== 1'b1 || almost_full !== 1'b1 || cnt_of(3) !== 6'd32 || free_count !== 6'd0)
         $display("FAIL fill_full: full=%0b af=%0b count3=%0d free=%0d, required 1/1/32/0", full, almost_full, cnt_of(3), free_count);
      else passed++;
      cyc(1'b1, 3'd3, 8'd99, 1'b0, 3'd0);
      total++;
      if (overflow !== 1'b1 || cnt_of(3) !== 6'd32 || free_count !== 6'd0)
         $display("FAIL fill_overflow: ovf=%0b count3=%0d free=%0d, required 1/32/0", overflow, cnt_of(3), free_count);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
      total++;
      if (overflow !== 1'b0) $display("FAIL fill_overflow_pulse: ovf=%0b, required 0", overflow);
      else passed++;
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd3);
         if (q !== 8'(i) || q_valid !== 1'b1 || q_fifo !== 3'd3) begin
            bad++;
            $display("FAIL fill_pop%0d: q=%0d valid=%0b fifo=%0d, required %0d/1/3", i, q, q_valid, q_fifo, i);
         end
      end
      total++;
      if (bad == 0) passed++;
      total++;
      if (free_count !== 6'd32 || empty !== 8'hFF || full !== 1'b0)
         $display("FAIL fill_drained: free=%0d empty=%0h full=%0b, required 32/ff/0", free_count, empty, full);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
      total++;
      if (q_valid !== 1'b0 || q !== 8'd31)
         $display("FAIL fill_q_hold: valid=%0b q=%0d, required 0/31", q_valid, q);
      else passed++;
   endtask

   task automatic test_interleave();
      cyc(1'b1, 3'd0, 8'hA0, 1'b0, 3'd0);
      cyc(1'b1, 3'd1, 8'hB0, 1'b0, 3'd0);
      cyc(1'b1, 3'd0, 8'hA1, 1'b0, 3'd0);
      cyc(1'b1, 3'd1, 8'hB1, 1'b0, 3'd0);
      total++;
      if (cnt_of(0) !== 6'd2 || cnt_of(1) !== 6'd2 || free_count !== 6'd28 || empty !== 8'hFC)
         $display("FAIL ilv_counts: c0=%0d c1=%0d free=%0d empty=%0h, required 2/2/28/fc", cnt_of(0), cnt_of(1), free_count, empty);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd1);
      total++;
      if (q !== 8'hB0 || q_fifo !== 3'd1 || q_valid !== 1'b1) $display("FAIL ilv_b0: q=%0h fifo=%0d, required b0/1", q, q_fifo);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd1);
      total++;
      if (q !== 8'hB1 || q_fifo !== 3'd1) $display("FAIL ilv_b1: q=%0h fifo=%0d, required b1/1", q, q_fifo);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
      total++;
      if (q !== 8'hA0 || q_fifo !== 3'd0) $display("FAIL ilv_a0: q=%0h fifo=%0d, required a0/0", q, q_fifo);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
      total++;
      if (q !== 8'hA1 || q_fifo !== 3'd0 || free_count !== 6'd32)
         $display("FAIL ilv_a1: q=%0h fifo=%0d free=%0d, required a1/0/32", q, q_fifo, free_count);
      else passed++;
   endtask

   task automatic test_same_queue();
      cyc(1'b1, 3'd2, 8'd5, 1'b0, 3'd0);
      cyc(1'b1, 3'd2, 8'd6, 1'b1, 3'd2);
      total++;
      if (q !== 8'd5 || q_valid !== 1'b1 || q_fifo !== 3'd2 || cnt_of(2) !== 6'd1 || free_count !== 6'd31)
         $display("FAIL sameq_pushpop: q=%0d valid=%0b fifo=%0d c2=%0d free=%0d, required 5/1/2/1/31",
                  q, q_valid, q_fifo, cnt_of(2), free_count);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd2);
      total++;
      if (q !== 8'd6 || cnt_of(2) !== 6'd0 || free_count !== 6'd32)
         $display("FAIL sameq_second: q=%0d c2=%0d free=%0d, required 6/0/32", q, cnt_of(2), free_count);
      else passed++;
      cyc(1'b1, 3'd4, 8'd7, 1'b1, 3'd4);
      total++;
      if (underflow !== 1'b1 || q_valid !== 1'b0 || cnt_of(4) !== 6'd1 || free_count !== 6'd31)
         $display("FAIL sameq_empty: unf=%0b valid=%0b c4=%0d free=%0d, required 1/0/1/31", underflow, q_valid, cnt_of(4), free_count);
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd4);
      total++;
      if (q !== 8'd7 || underflow !== 1'b0 || empty !== 8'hFF)
         $display("FAIL sameq_empty_pop: q=%0d unf=%0b empty=%0h, required 7/0/ff", q, underflow, empty);
      else passed++;
   endtask

   task automatic test_full_mixed();
      for (int i = 0; i < 31; i++) cyc(1'b1, 3'd3, 8'(100 + i), 1'b0, 3'd0);
      cyc(1'b1, 3'd1, 8'd55, 1'b0, 3'd0);
      total++;
      if (full !== 1'b1) $display("FAIL mixed_full: full=%0b, required 1", full);
      else passed++;
      cyc(1'b1, 3'd0, 8'd77, 1'b1, 3'd1);
      total++;
      if (overflow !== 1'b1 || underflow !== 1'b0 || q_valid !== 1'b1 || q !== 8'd55 || free_count !== 6'd1 || cnt_of(0) !== 6'd0 || cnt_of(1) !== 6'd0)
         $display("FAIL mixed_pushpop: ovf=%0b unf=%0b valid=%0b q=%0d free=%0d c0=%0d c1=%0d, required 1/0/1/55/1/0/0",
                  overflow, underflow, q_valid, q, free_count, cnt_of(0), cnt_of(1));
      else passed++;
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd3);
      total++;
      if (q !== 8'd100 || q_fifo !== 3'd3 || almost_full !== 1'b0 || free_count !== 6'd2)
         $display("FAIL mixed_head3: q=%0d fifo=%0d af=%0b free=%0d, required 100/3/0/2", q, q_fifo, almost_full, free_count);
      else passed++;
   endtask

   task automatic test_midrun_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_ready();
      for (int i = 0; i < 10; i++) cyc(1'b1, 3'd5, 8'(i + 1), 1'b0, 3'd0);
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd5);
      total++;
      if (q !== 8'd1 || q_valid !== 1'b1 || cnt_of(5) !== 6'd9)
         $display("FAIL midrst_before: q=%0d valid=%0b c5=%0d, required 1/1/9", q, q_valid, cnt_of(5));
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (q !== 8'd0 || q_valid !== 1'b0 || q_fifo !== 3'd0 || ready !== 1'b0 || count !== 48'h0 || empty !== 8'hFF || free_count !== 6'd32)
         $display("FAIL midrst_async: q=%0d valid=%0b fifo=%0d ready=%0b count=%0h empty=%0h free=%0d, required 0/0/0/0/0/ff/32",
                  q, q_valid, q_fifo, ready, count, empty, free_count);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      wait_ready();
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd5);
      total++;
      if (underflow !== 1'b1 || q_valid !== 1'b0 || cnt_of(5) !== 6'd0)
         $display("FAIL midrst_after: unf=%0b valid=%0b c5=%0d, required 1/0/0", underflow, q_valid, cnt_of(5));
      else passed++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_interleave();
      test_same_queue();
      test_full_mixed();
      test_midrun_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
